// File: rtl/prog_sequencer_if.sv
// Handshake/bus bundle between the instruction feeder and its neighbours.
//   master : upstream controller + proc side (drives Start, WrEn, WrAddr, WrData, Done)
//   slave  : prog_sequencer (drives DIN, Run, PC, Busy, Halted)
// Parameter ADDR_W sets the width of WrAddr and PC.
interface prog_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned WORD_W = 9;

    logic              Start;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [WORD_W-1:0] WrData;
    logic              Done;
    logic [WORD_W-1:0] DIN;
    logic              Run;
    logic [ADDR_W-1:0] PC;
    logic              Busy;
    logic              Halted;

    modport master (
        output Start, WrEn, WrAddr, WrData, Done,
        input  DIN, Run, PC, Busy, Halted
    );

    modport slave (
        input  Start, WrEn, WrAddr, WrData, Done,
        output DIN, Run, PC, Busy, Halted
    );
endinterface

// File: rtl/prog_sequencer.sv
// prog_sequencer: instruction feeder upstream of the proc datapath.
// Holds a 2**ADDR_W x 9 program memory, issues each word to proc with a one-cycle
// Run pulse, waits for Done, and drives the mvi immediate on DIN while proc runs it.
// HALT_WORD stops sequencing; memory is writable only while IDLE or HALT.
// Ports:
//   Clock   in   system clock, rising edge
//   Resetn  in   asynchronous active-low reset
//   Step    in   (SEQ_SINGLE_STEP_EN only) advance out of PAUSE
//   bus     slave modport of prog_sequencer_if:
//           Start/WrEn/WrAddr/WrData/Done in, DIN/Run/PC/Busy/Halted out (registered)
// Optional feature: define SEQ_SINGLE_STEP_EN to add the Step input and a PAUSE
// state entered after every Done.
module prog_sequencer #(
    parameter int unsigned ADDR_W    = 5,
    parameter logic [2:0]  MVI_OP    = 3'b001,
    parameter logic [8:0]  HALT_WORD = 9'h1FF
) (
    input logic Clock,
    input logic Resetn,
`ifdef SEQ_SINGLE_STEP_EN
    input logic Step,
`endif
    prog_sequencer_if.slave bus
);
    localparam int unsigned WORD_W = 9;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_HALT} state_t;
`endif

    state_t state_q, state_d;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [WORD_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              issued_mvi_q, issued_mvi_d;

    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_plus2;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] nxt_word;
    logic              wr_allowed;

    // PC arithmetic wraps naturally at ADDR_W bits
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign pc_plus2 = pc_q + ADDR_W'(2);
    assign cur_word = mem[pc_q];
    assign nxt_word = mem[pc_plus1];

    assign wr_allowed = (state_q == S_IDLE) || (state_q == S_HALT);

    // Program memory write port; contents deliberately survive reset
    always_ff @(posedge Clock) begin
        if (bus.WrEn && wr_allowed) begin
            mem[bus.WrAddr] <= bus.WrData;
        end
    end

    // State and registered outputs
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            din_q        <= '0;
            run_q        <= 1'b0;
            pc_q         <= '0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            issued_mvi_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            din_q        <= din_d;
            run_q        <= run_d;
            pc_q         <= pc_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            issued_mvi_q <= issued_mvi_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = (cur_word == HALT_WORD) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
`ifdef SEQ_SINGLE_STEP_EN
                if (bus.Done) state_d = S_PAUSE;
`else
                if (bus.Done) state_d = S_ISSUE;
`endif
            end
            S_HALT: begin
                if (bus.Start) state_d = S_ISSUE;
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (Step) state_d = S_ISSUE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        din_d        = din_q;
        run_d        = 1'b0;
        pc_d         = pc_q;
        issued_mvi_d = issued_mvi_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.Start) pc_d = '0;
            end
            S_ISSUE: begin
                if (cur_word == HALT_WORD) begin
                    din_d = '0;
                end else begin
                    din_d        = cur_word;
                    run_d        = 1'b1;
                    issued_mvi_d = (cur_word[8:6] == MVI_OP);
                end
            end
            S_EXEC: begin
                // mvi: the word after the opcode is the immediate proc reads next
                if (issued_mvi_q) din_d = nxt_word;
                if (bus.Done) pc_d = issued_mvi_q ? pc_plus2 : pc_plus1;
            end
            default: begin
            end
        endcase
        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    assign bus.DIN    = din_q;
    assign bus.Run    = run_q;
    assign bus.PC     = pc_q;
    assign bus.Busy   = busy_q;
    assign bus.Halted = halted_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed vector table, hand-written
// reset / wrap sequences, and randomized programs checked by an instruction-level model.
module tb_prog_sequencer;
    localparam int unsigned AW  = 5;
    localparam int unsigned AW2 = 2;
    localparam logic [8:0]  HALT = 9'h1FF;
    localparam logic [2:0]  MVI  = 3'b001;

    logic Clock = 1'b0;
    logic Resetn;

    always #5 Clock = ~Clock;

    prog_sequencer_if #(.ADDR_W(AW))  b5 ();
    prog_sequencer_if #(.ADDR_W(AW2)) b2 ();

    prog_sequencer #(.ADDR_W(AW)) u_dut5 (
        .Clock  (Clock),
        .Resetn (Resetn),
`ifdef SEQ_SINGLE_STEP_EN
        .Step   (1'b1),
`endif
        .bus    (b5)
    );

    prog_sequencer #(.ADDR_W(AW2)) u_dut2 (
        .Clock  (Clock),
        .Resetn (Resetn),
`ifdef SEQ_SINGLE_STEP_EN
        .Step   (1'b1),
`endif
        .bus    (b2)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic          start;
        logic          done;
        logic          wren;
        logic [AW-1:0] wraddr;
        logic [8:0]    wrdata;
        logic          run;
        logic [8:0]    din;
        logic [AW-1:0] pc;
        logic          busy;
        logic          halted;
    } vec_t;

    vec_t tbl[$];

    function automatic void add_vec(input logic st, input logic dn, input logic we,
                                    input logic [AW-1:0] wa, input logic [8:0] wd,
                                    input logic r, input logic [8:0] d,
                                    input logic [AW-1:0] p, input logic bz, input logic h);
        vec_t v;
        v.start = st; v.done = dn; v.wren = we; v.wraddr = wa; v.wrdata = wd;
        v.run = r; v.din = d; v.pc = p; v.busy = bz; v.halted = h;
        tbl.push_back(v);
    endfunction

    task automatic chk5(input string nm, input logic r, input logic [8:0] d,
                        input logic [AW-1:0] p, input logic bz, input logic h);
        vectors++;
        if (b5.Run !== r || b5.DIN !== d || b5.PC !== p || b5.Busy !== bz || b5.Halted !== h) begin
            miscompares++;
            $display("FAIL %s: got run=%0b din=%h pc=%0d busy=%0b halted=%0b, want run=%0b din=%h pc=%0d busy=%0b halted=%0b",
                     nm, b5.Run, b5.DIN, b5.PC, b5.Busy, b5.Halted, r, d, p, bz, h);
        end
    endtask

    task automatic chk2(input string nm, input logic r, input logic [8:0] d,
                        input logic [AW2-1:0] p, input logic bz, input logic h);
        vectors++;
        if (b2.Run !== r || b2.DIN !== d || b2.PC !== p || b2.Busy !== bz || b2.Halted !== h) begin
            miscompares++;
            $display("FAIL %s: got run=%0b din=%h pc=%0d busy=%0b halted=%0b, want run=%0b din=%h pc=%0d busy=%0b halted=%0b",
                     nm, b2.Run, b2.DIN, b2.PC, b2.Busy, b2.Halted, r, d, p, bz, h);
        end
    endtask

    // Drive one cycle of inputs on the 5-bit instance and check after the edge
    task automatic cyc5(input string nm, input logic st, input logic dn, input logic we,
                        input logic [AW-1:0] wa, input logic [8:0] wd,
                        input logic r, input logic [8:0] d, input logic [AW-1:0] p,
                        input logic bz, input logic h);
        b5.Start = st; b5.Done = dn; b5.WrEn = we; b5.WrAddr = wa; b5.WrData = wd;
        @(posedge Clock); #1;
        chk5(nm, r, d, p, bz, h);
    endtask

    task automatic cyc2(input string nm, input logic st, input logic dn, input logic we,
                        input logic [AW2-1:0] wa, input logic [8:0] wd,
                        input logic r, input logic [8:0] d, input logic [AW2-1:0] p,
                        input logic bz, input logic h);
        b2.Start = st; b2.Done = dn; b2.WrEn = we; b2.WrAddr = wa; b2.WrData = wd;
        @(posedge Clock); #1;
        chk2(nm, r, d, p, bz, h);
    endtask

    task automatic do_reset();
        b5.Start = 1'b0; b5.Done = 1'b0; b5.WrEn = 1'b0;
        b2.Start = 1'b0; b2.Done = 1'b0; b2.WrEn = 1'b0;
        Resetn = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
    endtask

    // Randomized-run state
    logic [8:0]    m [32];
    logic [AW-1:0] pcm;
    logic [AW-1:0] npc;
    logic          halted_m;
    logic          mv;
    logic [8:0]    iw;
    logic [8:0]    ex;
    logic          rwe;
    logic [AW-1:0] rwa;
    logic [8:0]    rwd;
    int            dly;

    initial begin
        b5.Start = 1'b0; b5.Done = 1'b0; b5.WrEn = 1'b0; b5.WrAddr = '0; b5.WrData = '0;
        b2.Start = 1'b0; b2.Done = 1'b0; b2.WrEn = 1'b0; b2.WrAddr = '0; b2.WrData = '0;

        // Reset held with Start high
        Resetn   = 1'b0;
        b5.Start = 1'b1;
        b2.Start = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk5("reset5", 1'b0, 9'h000, 5'd0, 1'b0, 1'b0);
        chk2("reset2", 1'b0, 9'h000, 2'd0, 1'b0, 1'b0);
        b5.Start = 1'b0;
        b2.Start = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        @(posedge Clock); #1;

        // mv then HALT; Done 1 cycle after Run; Done ignored in IDLE and HALT
        add_vec(0, 0, 1, 5'd0, 9'h00A,  0, 9'h000, 5'd0, 0, 0);
        add_vec(0, 0, 1, 5'd1, HALT,    0, 9'h000, 5'd0, 0, 0);
        add_vec(1, 1, 0, 5'd0, 9'h000,  0, 9'h000, 5'd0, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  1, 9'h00A, 5'd0, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  0, 9'h00A, 5'd0, 1, 0);
        add_vec(0, 1, 0, 5'd0, 9'h000,  0, 9'h00A, 5'd1, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  0, 9'h000, 5'd1, 0, 1);
        add_vec(0, 1, 0, 5'd0, 9'h000,  0, 9'h000, 5'd1, 0, 1);
        // mvi program loaded while halted; write and Start during EXEC ignored
        add_vec(0, 0, 1, 5'd0, 9'h058,  0, 9'h000, 5'd1, 0, 1);
        add_vec(0, 0, 1, 5'd1, 9'h05A,  0, 9'h000, 5'd1, 0, 1);
        add_vec(0, 0, 1, 5'd2, HALT,    0, 9'h000, 5'd1, 0, 1);
        add_vec(1, 0, 0, 5'd0, 9'h000,  0, 9'h000, 5'd0, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  1, 9'h058, 5'd0, 1, 0);
        add_vec(1, 0, 1, 5'd1, 9'h0AA,  0, 9'h05A, 5'd0, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  0, 9'h05A, 5'd0, 1, 0);
        add_vec(0, 1, 0, 5'd0, 9'h000,  0, 9'h05A, 5'd2, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  0, 9'h000, 5'd2, 0, 1);
        // Start with simultaneous write to address 0: first issue sees new word;
        // Done in the Run cycle; immediate from mem[1] proves the EXEC write was dropped
        add_vec(1, 0, 1, 5'd0, 9'h05C,  0, 9'h000, 5'd0, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  1, 9'h05C, 5'd0, 1, 0);
        add_vec(0, 1, 0, 5'd0, 9'h000,  0, 9'h05A, 5'd2, 1, 0);
        add_vec(0, 0, 0, 5'd0, 9'h000,  0, 9'h000, 5'd2, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc5($sformatf("tbl[%0d]", i), tbl[i].start, tbl[i].done, tbl[i].wren,
                 tbl[i].wraddr, tbl[i].wrdata, tbl[i].run, tbl[i].din, tbl[i].pc,
                 tbl[i].busy, tbl[i].halted);
        end

        // Reset pulsed mid-EXEC of an add; program survives, restart from PC 0
        cyc5("rst_ld0", 0, 0, 1, 5'd0, 9'h081, 0, 9'h000, 5'd2, 0, 1);
        cyc5("rst_ld1", 0, 0, 1, 5'd1, HALT,   0, 9'h000, 5'd2, 0, 1);
        cyc5("rst_st",  1, 0, 0, 5'd0, 9'h000, 0, 9'h000, 5'd0, 1, 0);
        cyc5("rst_run", 0, 0, 0, 5'd0, 9'h000, 1, 9'h081, 5'd0, 1, 0);
        cyc5("rst_ex",  0, 0, 0, 5'd0, 9'h000, 0, 9'h081, 5'd0, 1, 0);
        #2;
        Resetn = 1'b0;
        #1;
        chk5("rst_async", 1'b0, 9'h000, 5'd0, 1'b0, 1'b0);
        #1;
        Resetn = 1'b1;
        @(posedge Clock); #1;
        chk5("rst_idle", 1'b0, 9'h000, 5'd0, 1'b0, 1'b0);
        cyc5("rer_st",  1, 0, 0, 5'd0, 9'h000, 0, 9'h000, 5'd0, 1, 0);
        cyc5("rer_run", 0, 0, 0, 5'd0, 9'h000, 1, 9'h081, 5'd0, 1, 0);
        cyc5("rer_dn",  0, 1, 0, 5'd0, 9'h000, 0, 9'h081, 5'd1, 1, 0);
        cyc5("rer_hlt", 0, 0, 0, 5'd0, 9'h000, 0, 9'h000, 5'd1, 0, 1);

        // ADDR_W=2: mvi at last address takes its immediate from address 0, PC wraps to 1
        cyc2("w_ld0", 0, 0, 1, 2'd0, 9'h123, 0, 9'h000, 2'd0, 0, 0);
        cyc2("w_ld1", 0, 0, 1, 2'd1, 9'h058, 0, 9'h000, 2'd0, 0, 0);
        cyc2("w_ld2", 0, 0, 1, 2'd2, 9'h0AB, 0, 9'h000, 2'd0, 0, 0);
        cyc2("w_ld3", 0, 0, 1, 2'd3, 9'h058, 0, 9'h000, 2'd0, 0, 0);
        cyc2("w_st",  1, 0, 0, 2'd0, 9'h000, 0, 9'h000, 2'd0, 1, 0);
        cyc2("w_r0",  0, 0, 0, 2'd0, 9'h000, 1, 9'h123, 2'd0, 1, 0);
        cyc2("w_d0",  0, 1, 0, 2'd0, 9'h000, 0, 9'h123, 2'd1, 1, 0);
        cyc2("w_r1",  0, 0, 0, 2'd0, 9'h000, 1, 9'h058, 2'd1, 1, 0);
        cyc2("w_i1",  0, 0, 0, 2'd0, 9'h000, 0, 9'h0AB, 2'd1, 1, 0);
        cyc2("w_d1",  0, 1, 0, 2'd0, 9'h000, 0, 9'h0AB, 2'd3, 1, 0);
        cyc2("w_r3",  0, 0, 0, 2'd0, 9'h000, 1, 9'h058, 2'd3, 1, 0);
        cyc2("w_i3",  0, 0, 0, 2'd0, 9'h000, 0, 9'h123, 2'd3, 1, 0);
        cyc2("w_d3",  0, 1, 0, 2'd0, 9'h000, 0, 9'h123, 2'd1, 1, 0);
        cyc2("w_rr",  0, 0, 0, 2'd0, 9'h000, 1, 9'h058, 2'd1, 1, 0);
        do_reset();
        chk2("w_rst", 1'b0, 9'h000, 2'd0, 1'b0, 1'b0);
        chk5("r_rst", 1'b0, 9'h000, 5'd0, 1'b0, 1'b0);

        // Random programs against an instruction-level model
        pcm      = '0;
        halted_m = 1'b0;
        for (int prog = 0; prog < 25; prog++) begin
            for (int a = 0; a < 32; a++) begin
                iw = 9'($urandom);
                if ($urandom_range(0, 3) == 0) iw[8:6] = MVI;
                if (iw == HALT) iw = 9'h000;
                m[a] = iw;
            end
            if (prog % 5 != 4) m[$urandom_range(3, 31)] = HALT;
            for (int a = 0; a < 32; a++) begin
                cyc5("rnd_load", 0, 1'($urandom_range(0, 1)), 1, 5'(a), m[a],
                     0, 9'h000, pcm, 0, halted_m);
            end
            rwe = 1'($urandom_range(0, 1));
            rwa = 5'($urandom);
            rwd = 9'($urandom);
            if (rwe) m[rwa] = rwd;
            cyc5("rnd_start", 1, 0, rwe, rwa, rwd, 0, 9'h000, 5'd0, 1, 0);
            pcm      = '0;
            halted_m = 1'b0;
            for (int k = 0; k < 40 && !halted_m; k++) begin
                iw = m[pcm];
                if (iw == HALT) begin
                    cyc5("rnd_halt", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 5'($urandom), 9'($urandom),
                         0, 9'h000, pcm, 0, 1);
                    halted_m = 1'b1;
                end else begin
                    cyc5("rnd_issue", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 5'($urandom), 9'($urandom),
                         1, iw, pcm, 1, 0);
                    mv  = (iw[8:6] == MVI);
                    npc = pcm + 5'd1;
                    ex  = mv ? m[npc] : iw;
                    dly = $urandom_range(0, 3);
                    for (int j = 0; j < dly; j++) begin
                        cyc5("rnd_wait", 1'($urandom_range(0, 1)), 0,
                             1'($urandom_range(0, 1)), 5'($urandom), 9'($urandom),
                             0, ex, pcm, 1, 0);
                    end
                    pcm = mv ? pcm + 5'd2 : pcm + 5'd1;
                    cyc5("rnd_done", 1'($urandom_range(0, 1)), 1,
                         1'($urandom_range(0, 1)), 5'($urandom), 9'($urandom),
                         0, ex, pcm, 1, 0);
                end
            end
            if (!halted_m) begin
                do_reset();
                pcm = '0;
                chk5("rnd_reset", 1'b0, 9'h000, pcm, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
